// File: rtl/usb_setup_decoder.sv
// usb_setup_decoder
//   Captures the 8-byte SETUP DATA0 payload from the usb core byte stream and
//   checks that exactly SETUP_LEN bytes arrived. On a good packet it presents the
//   decoded request fields, with a one-cycle pkt_valid pulse. Those fields feed
//   the control-endpoint response FSM.
//
// Optional feature macro: USB_SETUP_TIMEOUT_EN
//   When this macro is defined, a capture that sees no byte for TIMEOUT_CYC
//   cycles is abandoned and err_timeout pulses. When it is undefined,
//   err_timeout is tied to 0.
//
// Parameters
//   SETUP_LEN    required payload byte count (field decode assumes 8)
//   TIMEOUT_CYC  max clk_48 cycles between bytes while capturing
//
// Ports
//   clk_48              in   48 MHz clock
//   rst_n               in   asynchronous active-low reset
//   usb_rst             in   usb bus reset, synchronous clear
//   transaction_active  in   token accepted, transaction in progress
//   setup               in   current token is SETUP
//   data_strobe         in   level strobe, rising edge = one byte on data_out
//   data_out     [7:0]  in   received byte
//   success             in   packet CRC good (one-cycle pulse)
//   busy                out  capture in progress
//   pkt_valid           out  one-cycle pulse, new fields valid
//   err_len             out  one-cycle pulse, CRC-good packet of wrong length
//   err_timeout         out  one-cycle pulse, capture timed out
//   dir_in              out  bm_request_type[7]
//   bm_request_type [7:0], b_request [7:0], w_value/w_index/w_length [15:0]  out
module usb_setup_decoder #(
    parameter int SETUP_LEN   = 8,
    parameter int TIMEOUT_CYC = 4800
) (
    input  logic        clk_48,
    input  logic        rst_n,
    input  logic        usb_rst,
    input  logic        transaction_active,
    input  logic        setup,
    input  logic        data_strobe,
    input  logic [7:0]  data_out,
    input  logic        success,
    output logic        busy,
    output logic        pkt_valid,
    output logic        err_len,
    output logic        err_timeout,
    output logic        dir_in,
    output logic [7:0]  bm_request_type,
    output logic [7:0]  b_request,
    output logic [15:0] w_value,
    output logic [15:0] w_index,
    output logic [15:0] w_length
);

    // The count saturates at SETUP_LEN+1, so that an overlong packet never
    // wraps back to a count that looks valid.
    localparam int CNT_W = $clog2(SETUP_LEN + 2);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t           state;
    logic             strobe_q;
    logic             ta_q;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       cap_buf      [SETUP_LEN];
    logic [7:0]       cap_buf_next [SETUP_LEN];
    logic             byte_ev;
    logic             ta_rise;
    logic             store;
    logic [CNT_W:0]   final_cnt;

`ifdef USB_SETUP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;
`endif

    assign byte_ev   = data_strobe & ~strobe_q;
    assign ta_rise   = transaction_active & ~ta_q;
    assign store     = (state == CAPTURE) && byte_ev && (cnt < CNT_W'(SETUP_LEN));
    // A byte that arrives in the same cycle as success still counts toward
    // the packet length.
    assign final_cnt = {1'b0, cnt} + {{CNT_W{1'b0}}, byte_ev};
    assign busy      = (state == CAPTURE);

    // The buffer is kept apart from the output fields, so that an aborted or
    // bad capture never disturbs the fields already presented.
    always_comb begin
        cap_buf_next = cap_buf;
        for (int i = 0; i < SETUP_LEN; i++) begin
            if (store && (cnt == CNT_W'(i))) cap_buf_next[i] = data_out;
        end
    end

    always_ff @(posedge clk_48) begin
        cap_buf <= cap_buf_next;
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            strobe_q        <= 1'b0;
            ta_q            <= 1'b0;
            cnt             <= '0;
            pkt_valid       <= 1'b0;
            err_len         <= 1'b0;
            dir_in          <= 1'b0;
            bm_request_type <= '0;
            b_request       <= '0;
            w_value         <= '0;
            w_index         <= '0;
            w_length        <= '0;
`ifdef USB_SETUP_TIMEOUT_EN
            err_timeout     <= 1'b0;
            idle_cnt        <= '0;
`endif
        end else if (usb_rst) begin
            state           <= IDLE;
            strobe_q        <= 1'b0;
            ta_q            <= 1'b0;
            cnt             <= '0;
            pkt_valid       <= 1'b0;
            err_len         <= 1'b0;
            dir_in          <= 1'b0;
            bm_request_type <= '0;
            b_request       <= '0;
            w_value         <= '0;
            w_index         <= '0;
            w_length        <= '0;
`ifdef USB_SETUP_TIMEOUT_EN
            err_timeout     <= 1'b0;
            idle_cnt        <= '0;
`endif
        end else begin
            strobe_q  <= data_strobe;
            ta_q      <= transaction_active;
            pkt_valid <= 1'b0;
            err_len   <= 1'b0;
`ifdef USB_SETUP_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (ta_rise && setup) begin
                        state <= CAPTURE;
                        cnt   <= '0;
`ifdef USB_SETUP_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                CAPTURE: begin
                    if (byte_ev && (cnt < CNT_W'(SETUP_LEN + 1))) cnt <= cnt + 1'b1;
`ifdef USB_SETUP_TIMEOUT_EN
                    if (byte_ev) idle_cnt <= '0;
                    else         idle_cnt <= idle_cnt + 1'b1;
`endif
                    if (success) begin
                        state <= IDLE;
                        if (final_cnt == (CNT_W + 1)'(SETUP_LEN)) begin
                            pkt_valid       <= 1'b1;
                            bm_request_type <= cap_buf_next[0];
                            dir_in          <= cap_buf_next[0][7];
                            b_request       <= cap_buf_next[1];
                            w_value         <= {cap_buf_next[3], cap_buf_next[2]};
                            w_index         <= {cap_buf_next[5], cap_buf_next[4]};
                            w_length        <= {cap_buf_next[7], cap_buf_next[6]};
                        end else begin
                            err_len <= 1'b1;
                        end
                    end else if (ta_rise && setup) begin
                        // A fresh SETUP token restarts the capture in place.
                        cnt <= '0;
`ifdef USB_SETUP_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end else if (!transaction_active) begin
                        // A bad CRC or an aborted transaction: drop the capture quietly.
                        state <= IDLE;
                    end
`ifdef USB_SETUP_TIMEOUT_EN
                    else if (!byte_ev && (idle_cnt == TO_W'(TIMEOUT_CYC - 1))) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef USB_SETUP_TIMEOUT_EN
    assign err_timeout = 1'b0;
`endif

endmodule
